// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl: memory-game sequencer (LFSR symbols, LED playback, press check).
// Optional input timeout is enabled by defining SIMON_TIMEOUT_EN.
module simon_seq_ctrl #(
   parameter int          MAX_LEN        = 16,
   parameter int          SHOW_CYCLES    = 4,
   parameter int          GAP_CYCLES     = 2,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter logic [7:0]  LFSR_SEED      = 8'hA5,
   localparam int         LW             = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          btn_valid,
   input  logic [1:0]    btn_code,
   output logic          led_valid,
   output logic [1:0]    led_code,
   output logic          await_input,
   output logic [1:0]    cmp_seq,
   output logic [1:0]    cmp_player,
   input  logic          cmp_correct,
   output logic [LW-1:0] level,
   output logic          busy,
   output logic          win,
   output logic          lose
);

   localparam int IW = $clog2(MAX_LEN);
   localparam int CW = $clog2(SHOW_CYCLES + GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_ADD, S_SHOW, S_INPUT, S_CHECK, S_WIN, S_LOSE
   } state_t;

   state_t        state;
   logic [7:0]    lfsr;
   logic [1:0]    mem [MAX_LEN];
   logic [LW-1:0] len;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;
   logic [1:0]    player_reg;
   logic          last;

`ifdef SIMON_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
`endif

   if (MAX_LEN < 2 || SHOW_CYCLES < 1 || GAP_CYCLES < 1 ||
       TIMEOUT_CYCLES < 1 || LFSR_SEED == 8'h00) begin : g_bad_param
      $error("simon_seq_ctrl: illegal parameter value");
   end

   assign last       = (LW'(idx) == len - LW'(1));
   assign level      = len;
   assign cmp_seq    = mem[idx];
   assign cmp_player = player_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         lfsr        <= LFSR_SEED;
         len         <= '0;
         idx         <= '0;
         cnt         <= '0;
         player_reg  <= '0;
         for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
         led_valid   <= 1'b0;
         led_code    <= '0;
         await_input <= 1'b0;
         busy        <= 1'b0;
         win         <= 1'b0;
         lose        <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
         tcnt        <= '0;
`endif
      end else begin
         // Galois form of x^8+x^6+x^5+x^4+1, shifting right
         lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
         unique case (state)
            S_IDLE, S_WIN, S_LOSE: begin
               if (start) begin
                  len   <= '0;
                  idx   <= '0;
                  win   <= 1'b0;
                  lose  <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               mem[len[IW-1:0]] <= lfsr[1:0];
               len       <= len + LW'(1);
               idx       <= '0;
               cnt       <= '0;
               led_valid <= 1'b1;
               // first symbol of a new game is being written this cycle
               led_code  <= (len == '0) ? lfsr[1:0] : mem[0];
               state     <= S_SHOW;
            end
            S_SHOW: begin
               if (cnt == CW'(SHOW_CYCLES + GAP_CYCLES - 1)) begin
                  cnt <= '0;
                  if (last) begin
                     idx         <= '0;
                     await_input <= 1'b1;
                     state       <= S_INPUT;
`ifdef SIMON_TIMEOUT_EN
                     tcnt        <= '0;
`endif
                  end else begin
                     idx       <= idx + IW'(1);
                     led_valid <= 1'b1;
                     led_code  <= mem[idx + IW'(1)];
                  end
               end else begin
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(SHOW_CYCLES - 1)) begin
                     led_valid <= 1'b0;
                     led_code  <= '0;
                  end
               end
            end
            S_INPUT: begin
               if (btn_valid) begin
                  player_reg  <= btn_code;
                  await_input <= 1'b0;
                  state       <= S_CHECK;
`ifdef SIMON_TIMEOUT_EN
               end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  await_input <= 1'b0;
                  busy        <= 1'b0;
                  lose        <= 1'b1;
                  state       <= S_LOSE;
               end else begin
                  tcnt <= tcnt + TW'(1);
`endif
               end
            end
            S_CHECK: begin
               if (!cmp_correct) begin
                  busy  <= 1'b0;
                  lose  <= 1'b1;
                  state <= S_LOSE;
               end else if (!last) begin
                  idx         <= idx + IW'(1);
                  await_input <= 1'b1;
                  state       <= S_INPUT;
`ifdef SIMON_TIMEOUT_EN
                  tcnt        <= '0;
`endif
               end else if (len == LW'(MAX_LEN)) begin
                  busy  <= 1'b0;
                  win   <= 1'b1;
                  state <= S_WIN;
               end else begin
                  state <= S_ADD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb_simon_seq_ctrl: scoreboard bench for simon_seq_ctrl.
// Symbols come from a reference LFSR; LED playback is checked against a queue.
module tb_simon_seq_ctrl;

   localparam int MAXL  = 4;
   localparam int SHOWC = 4;
   localparam int GAPC  = 2;
   localparam int TOC   = 10;
   localparam int SLOT  = SHOWC + GAPC;
   localparam int LW    = $clog2(MAXL + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          btn_valid = 1'b0;
   logic [1:0]    btn_code = 2'b00;
   logic          led_valid;
   logic [1:0]    led_code;
   logic          await_input;
   logic [1:0]    cmp_seq;
   logic [1:0]    cmp_player;
   logic          cmp_correct;
   logic [LW-1:0] level;
   logic          busy;
   logic          win;
   logic          lose;

   int         n_run = 0;
   int         n_fail = 0;
   logic [7:0] m_lfsr;
   logic [1:0] seq [$];
   logic [1:0] exp_q [$];
   logic       led_q = 1'b0;

   assign cmp_correct = (cmp_seq == cmp_player);

   simon_seq_ctrl #(
      .MAX_LEN        (MAXL),
      .SHOW_CYCLES    (SHOWC),
      .GAP_CYCLES     (GAPC),
      .TIMEOUT_CYCLES (TOC),
      .LFSR_SEED      (8'hA5)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .btn_valid   (btn_valid),
      .btn_code    (btn_code),
      .led_valid   (led_valid),
      .led_code    (led_code),
      .await_input (await_input),
      .cmp_seq     (cmp_seq),
      .cmp_player  (cmp_player),
      .cmp_correct (cmp_correct),
      .level       (level),
      .busy        (busy),
      .win         (win),
      .lose        (lose)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int want);
      n_run++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // reference x^8+x^6+x^5+x^4+1 Galois LFSR
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 8'hA5;
      else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
   end

   always @(negedge clk) begin
      if (rst_n && led_valid && !led_q) begin
         if (exp_q.size() == 0) chk("led_extra", 1, 0);
         else chk("led_code", int'(led_code), int'(exp_q.pop_front()));
      end
      if (rst_n && !led_valid && led_q)
         chk("led_off_code", int'(led_code), 0);
      led_q <= led_valid;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // called in the ADD cycle: the new symbol is the current LFSR low bits
   task automatic add_sym();
      seq.push_back(m_lfsr[1:0]);
      foreach (seq[i]) exp_q.push_back(seq[i]);
   endtask

   task automatic wait_input(output int n);
      n = 0;
      while (!await_input && n < 200) begin
         tick();
         n++;
      end
      if (!await_input) chk("await_timeout", 0, 1);
   endtask

   task automatic begin_game();
      start = 1'b1;
      tick();
      start = 1'b0;
      seq.delete();
      chk("add_level", int'(level), 0);
      chk("add_busy", int'(busy), 1);
      add_sym();
      for (int c = 0; c < SLOT; c++) begin
         tick();
         chk("show_pat", int'(led_valid), int'(c < SHOWC));
         chk("show_lvl", int'(level), 1);
      end
      tick();
      chk("lvl1_await", int'(await_input), 1);
   endtask

   task automatic echo_level(input int lv, input bit poke, input bit both);
      int n;
      int extra;
      for (int i = 0; i < lv; i++) begin
         btn_valid = 1'b1;
         btn_code  = seq[i];
         start     = both && (i == 0);
         tick();
         btn_valid = 1'b0;
         start     = 1'b0;
         chk("chk_player", int'(cmp_player), int'(seq[i]));
         chk("chk_seq", int'(cmp_seq), int'(seq[i]));
         chk("chk_await", int'(await_input), 0);
         tick();
         if (i < lv - 1) chk("next_await", int'(await_input), 1);
      end
      if (lv < MAXL) begin
         chk("add_lvl", int'(level), lv);
         add_sym();
         extra = 0;
         if (poke) begin
            tick();
            tick();
            btn_valid = 1'b1;
            btn_code  = ~seq[0];
            tick();
            btn_valid = 1'b0;
            extra = 3;
         end
         wait_input(n);
         chk("play_len", n + extra, SLOT * (lv + 1) + 1);
         chk("level", int'(level), lv + 1);
      end else begin
         chk("win", int'(win), 1);
         chk("win_busy", int'(busy), 0);
         chk("win_lvl", int'(level), lv);
      end
   endtask

   initial begin
      int n;
      repeat (3) tick();
      chk("rst_outs", int'({led_valid, led_code, await_input, busy,
                            win, lose, level, cmp_seq, cmp_player}), 0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_busy", int'(busy), 0);
      chk("idle_led", int'(led_valid), 0);
      chk("idle_lvl", int'(level), 0);

      begin_game();
      echo_level(1, 1'b1, 1'b0);
      echo_level(2, 1'b0, 1'b1);

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_in_input", int'({await_input, busy, level}),
          int'({1'b1, 1'b1, LW'(3)}));

      btn_valid = 1'b1;
      btn_code  = seq[0];
      tick();
      btn_valid = 1'b0;
      tick();
      chk("l3_first_ok", int'(await_input), 1);
      btn_valid = 1'b1;
      btn_code  = seq[1] ^ 2'b01;
      tick();
      btn_valid = 1'b0;
      chk("wrong_player", int'(cmp_player), int'(seq[1] ^ 2'b01));
      chk("wrong_lose_early", int'(lose), 0);
      tick();
      chk("lose", int'(lose), 1);
      chk("lose_lvl", int'(level), 3);
      chk("lose_busy", int'(busy), 0);
      tick();
      chk("lose_hold", int'({lose, level}), int'({1'b1, LW'(3)}));

      begin_game();
      for (int lv = 1; lv <= MAXL; lv++) echo_level(lv, 1'b0, 1'b0);
      repeat (3) tick();
      chk("win_hold", int'({win, busy, lose}), 4);

`ifdef SIMON_TIMEOUT_EN
      begin_game();
      repeat (TOC - 1) tick();
      chk("to_still_wait", int'(await_input), 1);
      tick();
      chk("to_lose", int'(lose), 1);
      chk("to_await", int'(await_input), 0);

      begin_game();
      repeat (TOC - 1) tick();
      btn_valid = 1'b1;
      btn_code  = seq[0];
      tick();
      btn_valid = 1'b0;
      chk("to_press_lose", int'(lose), 0);
      chk("to_press_check", int'(cmp_player), int'(seq[0]));
      tick();
      add_sym();
      wait_input(n);
      chk("to_press_lvl", int'(level), 2);
`else
      begin_game();
      repeat (30) tick();
      chk("no_to_wait", int'({await_input, lose}), 2);
`endif

      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
